vic_scan_doubler: RTL and testbench

- Sits directly downstream of the VIC-II video generator.
- Captures its 8 MHz pixel stream (4-bit colour index, hsync, vsync, visible) into ping-pong line buffers.
- Replays each captured line twice at 16 MHz pixel rate, converting the index to 24-bit RGB.
- Result: a ~31 kHz VGA-class raster for the board video output.

---
 rtl/video_pkg.sv | 26 ++
 rtl/c64_palette.sv | 35 +++
 rtl/vic_scan_doubler.sv | 213 +++++++++++++++++++++
 tb/tb_vic_scan_doubler.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
// Shared video definitions for the VIC-II scan doubler path.
//   P_LINE_PIXELS_PAL : input pixels per PAL raster line (X = 0..0x1f7)
//   pixel_t           : one line-buffer entry, {visib, color}
//   C64_PALETTE       : fixed 16-entry colour index to 24-bit RGB table
// No ports; imported by c64_palette and vic_scan_doubler.
// -----------------------------------------------------------------------------
package video_pkg;

    localparam int P_LINE_PIXELS_PAL = 504;
    localparam int PALETTE_SIZE      = 16;

    typedef struct packed {
        logic       visib;
        logic [3:0] color;
    } pixel_t;

    localparam logic [23:0] C64_PALETTE [PALETTE_SIZE] = '{
        24'h000000, 24'hFFFFFF, 24'h68372B, 24'h70A4B2,
        24'h6F3D86, 24'h588D43, 24'h352879, 24'hB8C76F,
        24'h6F4F25, 24'h433900, 24'h9A6759, 24'h444444,
        24'h6C6C6C, 24'h9AD284, 24'h6C5EB5, 24'h959595
    };

endpackage

// File: rtl/c64_palette.sv
// -----------------------------------------------------------------------------
// c64_palette
// Registered colour lookup: converts a 4-bit C64 colour index into 24-bit RGB.
// The output register only loads when en_i is high.
//   clk    in   1   system clock
//   rst    in   1   asynchronous reset, active-low (output register -> 0)
//   en_i   in   1   load enable
//   idx_i  in   4   colour index
//   rgb_o  out  24  {R, G, B}, one enabled cycle after idx_i
// -----------------------------------------------------------------------------
module c64_palette
    import video_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic [3:0]  idx_i,
    output logic [23:0] rgb_o
);

    logic [23:0] rgb_q;

    // NOTE: clocked state is assigned with <= so every register samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb_q <= '0;
        end else if (en_i) begin
            rgb_q <= C64_PALETTE[idx_i];
        end
    end

    assign rgb_o = rgb_q;

endmodule

// File: rtl/vic_scan_doubler.sv
// -----------------------------------------------------------------------------
// vic_scan_doubler
// Captures the VIC-II 8 MHz pixel stream into ping-pong line buffers and
// replays every captured line twice at 16 MHz, producing RGB plus VGA-style
// syncs. The write side fills bank wr_bank while the read side scans the
// other bank; each input hsync swaps the banks and resyncs the reader.
//   clk           in   1  system clock
//   rst           in   1  asynchronous reset, active-low
//   clk_8mhz_en   in   1  input pixel enable
//   clk_16mhz_en  in   1  output pixel enable (2x clk_8mhz_en rate)
//   i_color       in   4  VIC-II colour index
//   i_hsync       in   1  VIC-II hsync (one input pixel wide)
//   i_vsync       in   1  VIC-II vsync (one input pixel wide)
//   i_visib       in   1  VIC-II visible-area flag
//   o_r/o_g/o_b   out  8  colour channels, 0 while o_de=0
//   o_hsync       out  1  output hsync, active-high
//   o_vsync       out  1  output vsync, active-high
//   o_de          out  1  data enable
// -----------------------------------------------------------------------------
module vic_scan_doubler
    import video_pkg::*;
#(
    parameter int P_LINE_PIXELS = P_LINE_PIXELS_PAL,
    parameter int P_ADDR_W      = 9,
    parameter int P_HSYNC_WIDTH = 60,
    parameter int P_VSYNC_LINES = 4
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_8mhz_en,
    input  logic       clk_16mhz_en,
    input  logic [3:0] i_color,
    input  logic       i_hsync,
    input  logic       i_vsync,
    input  logic       i_visib,
    output logic [7:0] o_r,
    output logic [7:0] o_g,
    output logic [7:0] o_b,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_de
);

    localparam int DEPTH = 2 ** P_ADDR_W;
    localparam int VS_W  = $clog2(P_VSYNC_LINES + 1);

    localparam logic [P_ADDR_W-1:0] X_ONE  = P_ADDR_W'(1);
    localparam logic [P_ADDR_W-1:0] X_SAT  = P_ADDR_W'(DEPTH - 1);
    localparam logic [P_ADDR_W-1:0] X_LAST = P_ADDR_W'(P_LINE_PIXELS - 1);
    localparam logic [P_ADDR_W-1:0] HS_END = P_ADDR_W'(P_HSYNC_WIDTH);
    localparam logic [VS_W-1:0]     VS_ONE  = VS_W'(1);
    localparam logic [VS_W-1:0]     VS_LOAD = VS_W'(P_VSYNC_LINES);

    // ---------------------------------------------------------------- write side
    logic [P_ADDR_W-1:0] wr_x_q, wr_x_d;
    logic                wr_bank_q, wr_bank_d;
    logic                sol_q, sol_d;
    logic [1:0]          valid_q, valid_d;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        wr_x_d    = wr_x_q;
        wr_bank_d = wr_bank_q;
        valid_d   = valid_q;
        sol_d     = 1'b0;
        if (clk_8mhz_en) begin
            valid_d[wr_bank_q] = 1'b1;
            if (i_hsync) begin
                wr_x_d    = '0;
                wr_bank_d = ~wr_bank_q;
                sol_d     = 1'b1;
            end else if (wr_x_q != X_SAT) begin
                wr_x_d = wr_x_q + X_ONE;
            end
        end
    end

    // ----------------------------------------------------------------- read side
    logic [P_ADDR_W-1:0] rd_x_q, rd_x_d;
    logic                pass_q, pass_d;
    logic [P_ADDR_W-1:0] rd_addr;
    logic                rd_pass;
    logic                line_start;

    // SOL takes effect in the same cycle it is seen, so a coincident read
    // already fetches address 0 of the freshly released bank.
    always_comb begin
        rd_addr = sol_q ? '0   : rd_x_q;
        rd_pass = sol_q ? 1'b0 : pass_q;
        rd_x_d  = rd_x_q;
        pass_d  = pass_q;
        if (clk_16mhz_en) begin
            if (rd_addr == X_LAST) begin
                rd_x_d = '0;
                pass_d = ~rd_pass;
            end else begin
                rd_x_d = rd_addr + X_ONE;
                pass_d = rd_pass;
            end
        end else if (sol_q) begin
            rd_x_d = '0;
            pass_d = 1'b0;
        end
    end

    assign line_start = clk_16mhz_en && (rd_addr == '0);

    // ------------------------------------------------------------ vsync timing
    logic            vs_pend_q, vs_pend_d;
    logic [VS_W-1:0] vs_cnt_q, vs_cnt_d;

    // The set is applied after the service so a vsync landing on a line
    // start waits for the next pass-0 line start.
    always_comb begin
        vs_pend_d = vs_pend_q;
        vs_cnt_d  = vs_cnt_q;
        if (line_start) begin
            if (!rd_pass && vs_pend_q) begin
                vs_pend_d = 1'b0;
                vs_cnt_d  = VS_LOAD;
            end else if (vs_cnt_q != '0) begin
                vs_cnt_d = vs_cnt_q - VS_ONE;
            end
        end
        if (clk_8mhz_en && i_vsync) begin
            vs_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_x_q    <= '0;
            wr_bank_q <= 1'b0;
            sol_q     <= 1'b0;
            valid_q   <= '0;
            rd_x_q    <= '0;
            pass_q    <= 1'b0;
            vs_pend_q <= 1'b0;
            vs_cnt_q  <= '0;
        end else begin
            wr_x_q    <= wr_x_d;
            wr_bank_q <= wr_bank_d;
            sol_q     <= sol_d;
            valid_q   <= valid_d;
            rd_x_q    <= rd_x_d;
            pass_q    <= pass_d;
            vs_pend_q <= vs_pend_d;
            vs_cnt_q  <= vs_cnt_d;
        end
    end

    // -------------------------------------------------------------- line buffers
    // Two banks, selected by the MSB of the address.
    pixel_t              line_mem [2*DEPTH];
    pixel_t              rd_pix_q;
    logic [P_ADDR_W:0]   wr_ptr;
    logic [P_ADDR_W:0]   rd_ptr;

    assign wr_ptr = {wr_bank_q, wr_x_q};
    assign rd_ptr = {~wr_bank_q, rd_addr};

    // NOTE: the RAM and its read register carry no reset so they map onto
    // block RAM; stale contents are masked by the per-bank valid flags.
    always_ff @(posedge clk) begin
        if (clk_8mhz_en) begin
            line_mem[wr_ptr] <= {i_visib, i_color};
        end
        if (clk_16mhz_en) begin
            rd_pix_q <= line_mem[rd_ptr];
        end
    end

    // ------------------------------------------------------------------ pipeline
    // Stage 1 runs alongside the RAM read, stage 2 alongside the palette.
    logic        s1_valid_q, s1_hs_q, s1_vs_q;
    logic        de_q, hs_q, vs_q;
    logic [23:0] pal_rgb;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_hs_q    <= 1'b0;
            s1_vs_q    <= 1'b0;
            de_q       <= 1'b0;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
        end else if (clk_16mhz_en) begin
            s1_valid_q <= valid_q[~wr_bank_q];
            s1_hs_q    <= (rd_addr < HS_END);
            s1_vs_q    <= (vs_cnt_d != '0);
            de_q       <= s1_valid_q & rd_pix_q.visib;
            hs_q       <= s1_hs_q;
            vs_q       <= s1_vs_q;
        end
    end

    c64_palette u_palette (
        .clk   (clk),
        .rst   (rst),
        .en_i  (clk_16mhz_en),
        .idx_i (rd_pix_q.color),
        .rgb_o (pal_rgb)
    );

    assign o_r     = de_q ? pal_rgb[23:16] : '0;
    assign o_g     = de_q ? pal_rgb[15:8]  : '0;
    assign o_b     = de_q ? pal_rgb[7:0]   : '0;
    assign o_de    = de_q;
    assign o_hsync = hs_q;
    assign o_vsync = vs_q;

endmodule

// File: tb/tb_vic_scan_doubler.sv
// -----------------------------------------------------------------------------
// tb_vic_scan_doubler
// Randomised stimulus with a scoreboard: the stimulus side runs a behavioural
// line-doubler model and queues the expected output for every 16 MHz read;
// an independent monitor pops and compares two pixel steps later.
// -----------------------------------------------------------------------------
module tb_vic_scan_doubler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clk_8mhz_en = 1'b0;
    logic       clk_16mhz_en = 1'b0;
    logic [3:0] i_color = '0;
    logic       i_hsync = 1'b0;
    logic       i_vsync = 1'b0;
    logic       i_visib = 1'b0;
    logic [7:0] o_r, o_g, o_b;
    logic       o_hsync, o_vsync, o_de;

    vic_scan_doubler dut (
        .clk          (clk),
        .rst          (rst),
        .clk_8mhz_en  (clk_8mhz_en),
        .clk_16mhz_en (clk_16mhz_en),
        .i_color      (i_color),
        .i_hsync      (i_hsync),
        .i_vsync      (i_vsync),
        .i_visib      (i_visib),
        .o_r          (o_r),
        .o_g          (o_g),
        .o_b          (o_b),
        .o_hsync      (o_hsync),
        .o_vsync      (o_vsync),
        .o_de         (o_de)
    );

    always #5 clk = ~clk;

    localparam logic [23:0] PAL [16] = '{
        24'h000000, 24'hFFFFFF, 24'h68372B, 24'h70A4B2,
        24'h6F3D86, 24'h588D43, 24'h352879, 24'hB8C76F,
        24'h6F4F25, 24'h433900, 24'h9A6759, 24'h444444,
        24'h6C6C6C, 24'h9AD284, 24'h6C5EB5, 24'h959595
    };

    typedef struct {
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        de;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // ------------------------------------------------------------ reference model
    int m_buf [2][512];
    bit m_valid [2];
    int m_wx, m_wbank, m_rdx, m_pass, m_vs_pend, m_vs_cnt;
    bit m_sol;
    int phase, cyc;

    task automatic model_step();
        int   addr, pass, bank, ent;
        bit   vis;
        exp_t e;
        if (clk_16mhz_en) begin
            addr = m_sol ? 0 : m_rdx;
            pass = m_sol ? 0 : m_pass;
            bank = 1 - m_wbank;
            ent  = m_valid[bank] ? m_buf[bank][addr] : 0;
            vis  = (ent >= 16);
            if (addr == 0) begin
                if (pass == 0 && m_vs_pend != 0) begin
                    m_vs_cnt  = 4;
                    m_vs_pend = 0;
                end else if (m_vs_cnt > 0) begin
                    m_vs_cnt--;
                end
            end
            e.de  = vis;
            e.rgb = vis ? PAL[ent % 16] : 24'h0;
            e.hs  = (addr < 60);
            e.vs  = (m_vs_cnt != 0);
            sbq.push_back(e);
            if (addr == 503) begin
                m_rdx  = 0;
                m_pass = 1 - pass;
            end else begin
                m_rdx  = addr + 1;
                m_pass = pass;
            end
        end else if (m_sol) begin
            m_rdx  = 0;
            m_pass = 0;
        end
        if (clk_8mhz_en && i_vsync) m_vs_pend = 1;
        m_sol = 1'b0;
        if (clk_8mhz_en) begin
            m_buf[m_wbank][m_wx] = (i_visib ? 16 : 0) + int'(i_color);
            m_valid[m_wbank] = 1'b1;
            if (i_hsync) begin
                m_wx    = 0;
                m_wbank = 1 - m_wbank;
                m_sol   = 1'b1;
            end else if (m_wx < 511) begin
                m_wx++;
            end
        end
    endtask

    // ------------------------------------------------------------------ monitor
    logic mon_en, mon_rst;
    exp_t mon_e;
    int   vs_hi = 0, de_hi = 0, compared = 0;

    always @(posedge clk) begin
        mon_en  = clk_16mhz_en;
        mon_rst = rst;
        #1;
        if (mon_rst && rst && mon_en) begin
            vs_hi += int'(o_vsync);
            de_hi += int'(o_de);
            if (sbq.size() >= 2) begin
                mon_e = sbq.pop_front();
                compared++;
                check("rgb",   {8'h0, o_r, o_g, o_b}, {8'h0, mon_e.rgb});
                check("de",    32'(o_de),    32'(mon_e.de));
                check("hsync", 32'(o_hsync), 32'(mon_e.hs));
                check("vsync", 32'(o_vsync), 32'(mon_e.vs));
            end
        end
    end

    // ----------------------------------------------------------------- stimulus
    task automatic tick();
        @(negedge clk);
        cyc++;
        clk_16mhz_en = (phase == 0) ? (cyc % 2 == 0) : (cyc % 2 == 1);
        clk_8mhz_en  = (phase == 0) ? (cyc % 4 == 2) : (cyc % 4 == 0);
        if (rst) model_step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_pixel(input int color, input bit vis, input bit hs, input bit vs);
        i_color = 4'(color);
        i_visib = vis;
        i_hsync = hs;
        i_vsync = vs;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (clk_8mhz_en) break;
        end
    endtask

    // mode 0: random, 1: white 0..319, 2: colour ramp 0..15
    task automatic send_line(input int n, input int mode, input int vs_pos, input bit with_hs);
        for (int x = 0; x < n; x++) begin
            int c;
            bit v;
            c = $urandom_range(0, 15);
            v = ($urandom % 8) != 0;
            if (mode == 1) begin
                v = (x < 320);
                if (v) c = 1;
            end else if (mode == 2) begin
                v = (x < 16);
                c = x % 16;
            end
            send_pixel(c, v, with_hs && (x == n - 1), x == vs_pos);
        end
        i_hsync = 1'b0;
        i_vsync = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rgb"}, {8'h0, o_r, o_g, o_b}, 32'h0);
        check({tag, "_de"},    32'(o_de),    32'h0);
        check({tag, "_hsync"}, 32'(o_hsync), 32'h0);
        check({tag, "_vsync"}, 32'(o_vsync), 32'h0);
    endtask

    task automatic do_reset(input int ph);
        exp_t z;
        rst          = 1'b0;
        clk_8mhz_en  = 1'b0;
        clk_16mhz_en = 1'b0;
        i_color = '0; i_hsync = 1'b0; i_vsync = 1'b0; i_visib = 1'b0;
        #1;
        check_zero("reset");
        repeat (3) @(negedge clk);
        m_valid[0] = 1'b0; m_valid[1] = 1'b0;
        m_wx = 0; m_wbank = 0; m_rdx = 0; m_pass = 0;
        m_vs_pend = 0; m_vs_cnt = 0; m_sol = 1'b0;
        sbq.delete();
        z.rgb = '0; z.hs = 1'b0; z.vs = 1'b0; z.de = 1'b0;
        sbq.push_back(z);
        phase = ph;
        cyc   = 0;
        rst   = 1'b1;
    endtask

    initial begin
        int guard;
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 512; a++) m_buf[b][a] = 0;

        // ---- phase 0: enables coincide, so i_vsync can land on a line start
        do_reset(0);
        send_line(504, 1, -1, 1);
        send_line(504, 2, -1, 1);
        send_line(504, 0, -1, 1);
        vs_hi = 0;
        send_line(504, 0, 250, 1);
        repeat (4) send_line(504, 0, -1, 1);
        check("vsync_len_p0", 32'(vs_hi), 32'(4 * 504));
        send_line(300, 0, -1, 1);
        send_line(504, 0, -1, 1);
        send_line(530, 0, -1, 1);
        send_line(504, 0, -1, 1);

        // ---- reset in the middle of an output line
        i_hsync = 1'b0;
        i_vsync = 1'b0;
        guard = 0;
        while (m_rdx != 200 && guard < 5000) begin
            tick();
            guard++;
        end
        check("reach_rdx200", 32'(m_rdx), 32'd200);
        do_reset(0);

        // No hsync after reset: read bank never released, o_de must stay low.
        // i_vsync at pixel 504 lands exactly on a pass-0 line start.
        de_hi = 0;
        vs_hi = 0;
        send_line(1008, 0, 504, 0);
        check("de_after_reset", 32'(de_hi), 32'h0);
        check("vsync_coincide_deferred", 32'(vs_hi), 32'h0);
        repeat (3) send_line(504, 0, -1, 1);

        // ---- phase 1: SOL coincides with the output pixel enable
        do_reset(1);
        send_line(504, 1, -1, 1);
        send_line(504, 2, -1, 1);
        send_line(504, 0, -1, 1);
        send_line(300, 0, -1, 1);
        send_line(504, 0, -1, 1);
        vs_hi = 0;
        send_line(504, 0, 100, 1);
        repeat (3) send_line(504, 0, -1, 1);
        check("vsync_len_p1", 32'(vs_hi), 32'(4 * 504));
        repeat (4) tick();

        check("monitor_active", 32'(compared > 5000), 32'h1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
